// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multdiv sequential multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned     STEPS     = 32;
  localparam int unsigned     CNT_W     = 6;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
  localparam logic [31:0]     INT_MIN   = 32'h8000_0000;

  // Two's-complement magnitude; INT_MIN maps to 2^31 read as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter for multdiv: synchronous clear, count enable, and a flag
// that is high while the count sits at the last step index.
module multdiv_counter
  import multdiv_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic at_31
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign at_31 = (cnt_q == LAST_STEP);

endmodule

// File: rtl/multdiv.sv
// Sequential signed 32-bit multiplier / divider (shift-add and restoring
// shift-subtract on magnitudes, one step per cycle, 33-edge latency).
// Build option: MULTDIV_DIV0_FAST_EN completes divide-by-zero one edge after
// the start edge instead of running the full iteration.
module multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  state_e      state_q, state_d;
  logic        prep_q, prep_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] mag_q, mag_d;
  logic        neg_q, neg_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;

  logic        cnt_clr, cnt_en, at_31;

  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_step;
  logic [63:0] mul_final;
  logic [31:0] div_quo;
  logic [31:0] fin_result;
  logic        fin_exc;

  multdiv_counter u_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .at_31   (at_31)
  );

  // One iteration of each algorithm, plus the signed result it would finish with.
  // acc holds {hi, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
    mul_step = {mul_sum, acc_q[31:1]};

    div_ge   = (acc_q[63:31] >= {1'b0, mag_q});
    div_diff = acc_q[62:31] - mag_q;
    div_step = div_ge ? {div_diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};

    mul_final = neg_q ? (64'd0 - mul_step) : mul_step;
    div_quo   = div_step[31:0];

    if (state_q == MULT) begin
      fin_result = mul_final[31:0];
      fin_exc    = !((&mul_final[63:31]) || !(|mul_final[63:31]));
    end else if (mag_q == '0) begin
      fin_result = '0;
      fin_exc    = 1'b1;
    end else begin
      fin_result = neg_q ? (32'd0 - div_quo) : div_quo;
      // Only INT_MIN / -1 yields a positive quotient of 2^31.
      fin_exc    = !neg_q && div_quo[31];
    end
  end

  // Next-state and datapath control; a start overrides whatever is running.
  always_comb begin
    state_d  = state_q;
    prep_d   = 1'b0;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    acc_d    = acc_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    result_d = result_q;
    exc_d    = exc_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    case (state_q)
      IDLE: state_d = IDLE;
      MULT, DIV: begin
        if (prep_q) begin
          // First cycle after the start: reduce the latched operands to magnitudes.
          neg_d = op_a_q[31] ^ op_b_q[31];
          if (state_q == MULT) begin
            acc_d = {32'd0, mag32(op_b_q)};
            mag_d = mag32(op_a_q);
          end else begin
            acc_d = {32'd0, mag32(op_a_q)};
            mag_d = mag32(op_b_q);
`ifdef MULTDIV_DIV0_FAST_EN
            if (op_b_q == '0) begin
              state_d  = DONE;
              result_d = '0;
              exc_d    = 1'b1;
            end
`endif
          end
        end else begin
          cnt_en = 1'b1;
          acc_d  = (state_q == MULT) ? mul_step : div_step;
          if (at_31) begin
            state_d  = DONE;
            result_d = fin_result;
            exc_d    = fin_exc;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (ctrl_MULT || ctrl_DIV) begin
      state_d = ctrl_MULT ? MULT : DIV;
      prep_d  = 1'b1;
      op_a_d  = data_operandA;
      op_b_d  = data_operandB;
      cnt_clr = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      prep_q   <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      acc_q    <= '0;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prep_q   <= prep_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      acc_q    <= acc_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);

endmodule

// File: tb/tb_multdiv.sv
// Directed testbench for multdiv with hand-computed expected values.
module tb_multdiv;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_vec = 0;
  int n_err = 0;

  multdiv #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one start, scramble the operand inputs afterwards, and watch a
  // bounded number of edges for the completion strobe.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, input int max_edges,
                        output int first_edge, output int strobes,
                        output logic [31:0] res, output logic exc);
    @(posedge clock); #1;
    data_operandA = a; data_operandB = b; ctrl_MULT = m; ctrl_DIV = d;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'hDEAD_BEEF; data_operandB = 32'h0;
    first_edge = 0; strobes = 0; res = '0; exc = 1'b0;
    for (int k = 1; k <= max_edges; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        strobes++;
        if (first_edge == 0) begin
          first_edge = k; res = data_result; exc = data_exception;
        end
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'd11; data_operandB = 32'd13;
    #1;
    n_vec++; if (data_result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 00000000", data_result); end
    n_vec++; if (data_exception !== 1'b0) begin n_err++; $display("FAIL reset_exc got %b want 0", data_exception); end
    n_vec++; if (data_resultRDY !== 1'b0) begin n_err++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
  endtask

  task automatic test_mult;
    logic [31:0] ta [5] = '{32'd7, 32'h0001_0000, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tb [5] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'hFFFF_FFFA, 32'd1, 32'hFFFF_FFFF};
    logic [31:0] er [5] = '{32'hFFFF_FFEB, 32'h0, 32'd30, 32'h8000_0000, 32'h8000_0000};
    logic        ee [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int fe, ns; logic [31:0] r; logic x;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b1, 1'b0, ta[i], tb[i], 40, fe, ns, r, x);
      n_vec++; if (fe !== 33) begin n_err++; $display("FAIL mult%0d_rdy_edge got %0d want 33", i, fe); end
      n_vec++; if (ns !== 1) begin n_err++; $display("FAIL mult%0d_strobes got %0d want 1", i, ns); end
      n_vec++; if (r !== er[i]) begin n_err++; $display("FAIL mult%0d_result got %h want %h", i, r, er[i]); end
      n_vec++; if (x !== ee[i]) begin n_err++; $display("FAIL mult%0d_exc got %b want %b", i, x, ee[i]); end
      n_vec++; if (data_result !== er[i]) begin n_err++; $display("FAIL mult%0d_hold got %h want %h", i, data_result, er[i]); end
    end
  endtask

  task automatic test_div;
    logic [31:0] ta [6] = '{32'hFFFF_FF9C, 32'h8000_0000, 32'd100, 32'd7, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] tb [6] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'd1, 32'hFFFF_FFFE};
    logic [31:0] er [6] = '{32'hFFFF_FFF2, 32'h8000_0000, 32'hFFFF_FFF2, 32'h0, 32'h8000_0000, 32'd3};
    logic        ee [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int fe, ns; logic [31:0] r; logic x;
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, 1'b1, ta[i], tb[i], 40, fe, ns, r, x);
      n_vec++; if (fe !== 33) begin n_err++; $display("FAIL div%0d_rdy_edge got %0d want 33", i, fe); end
      n_vec++; if (ns !== 1) begin n_err++; $display("FAIL div%0d_strobes got %0d want 1", i, ns); end
      n_vec++; if (r !== er[i]) begin n_err++; $display("FAIL div%0d_result got %h want %h", i, r, er[i]); end
      n_vec++; if (x !== ee[i]) begin n_err++; $display("FAIL div%0d_exc got %b want %b", i, x, ee[i]); end
    end
  endtask

  task automatic test_div0;
    logic [31:0] ta [2] = '{32'd5, 32'hFFFF_FFFB};
    int fe, ns; logic [31:0] r; logic x;
`ifdef MULTDIV_DIV0_FAST_EN
    int exp_edge = 1;
`else
    int exp_edge = 33;
`endif
    for (int i = 0; i < 2; i++) begin
      run_op(1'b0, 1'b1, ta[i], 32'h0, 40, fe, ns, r, x);
      n_vec++; if (fe !== exp_edge) begin n_err++; $display("FAIL div0_%0d_rdy_edge got %0d want %0d", i, fe, exp_edge); end
      n_vec++; if (ns !== 1) begin n_err++; $display("FAIL div0_%0d_strobes got %0d want 1", i, ns); end
      n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL div0_%0d_result got %h want 00000000", i, r); end
      n_vec++; if (x !== 1'b1) begin n_err++; $display("FAIL div0_%0d_exc got %b want 1", i, x); end
    end
  endtask

  task automatic test_restart;
    int fe = 0, ns = 0; logic [31:0] r = '0; logic x = 1'b0;
    @(posedge clock); #1;
    data_operandA = 32'd2; data_operandB = 32'd3; ctrl_MULT = 1'b1;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 10) begin
        data_operandA = 32'd4; data_operandB = 32'd5; ctrl_MULT = 1'b1;
      end
      @(posedge clock); #1;
      if (k == 10) begin
        ctrl_MULT = 1'b0; data_operandA = 32'd99; data_operandB = 32'd99;
      end
      if (data_resultRDY) begin
        ns++;
        if (fe == 0) begin fe = k; r = data_result; x = data_exception; end
      end
    end
    n_vec++; if (fe !== 43) begin n_err++; $display("FAIL restart_rdy_edge got %0d want 43", fe); end
    n_vec++; if (ns !== 1) begin n_err++; $display("FAIL restart_strobes got %0d want 1", ns); end
    n_vec++; if (r !== 32'd20) begin n_err++; $display("FAIL restart_result got %h want 00000014", r); end
    n_vec++; if (x !== 1'b0) begin n_err++; $display("FAIL restart_exc got %b want 0", x); end
  endtask

  task automatic test_priority;
    int fe, ns; logic [31:0] r; logic x;
    run_op(1'b1, 1'b1, 32'd6, 32'd2, 40, fe, ns, r, x);
    n_vec++; if (fe !== 33) begin n_err++; $display("FAIL prio_rdy_edge got %0d want 33", fe); end
    n_vec++; if (r !== 32'd12) begin n_err++; $display("FAIL prio_result got %h want 0000000c", r); end
  endtask

  task automatic test_reset_mid;
    int fe = 0, ns = 0, early = 0; logic [31:0] r = '0; logic x = 1'b0;
    @(posedge clock); #1;
    data_operandA = 32'd1000; data_operandB = 32'd7; ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) early++;
    end
    reset_n = 1'b0;
    #1;
    n_vec++; if (early !== 0) begin n_err++; $display("FAIL rstmid_early_strobe got %0d want 0", early); end
    n_vec++; if (data_result !== 32'h0) begin n_err++; $display("FAIL rstmid_result got %h want 00000000", data_result); end
    n_vec++; if (data_exception !== 1'b0) begin n_err++; $display("FAIL rstmid_exc got %b want 0", data_exception); end
    n_vec++; if (data_resultRDY !== 1'b0) begin n_err++; $display("FAIL rstmid_rdy got %b want 0", data_resultRDY); end
    data_operandA = 32'd9; data_operandB = 32'd3; ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    n_vec++; if (data_resultRDY !== 1'b0) begin n_err++; $display("FAIL rstheld_rdy got %b want 0", data_resultRDY); end
    #3 reset_n = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0; data_operandA = 32'd50; data_operandB = 32'd0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        ns++;
        if (fe == 0) begin fe = k; r = data_result; x = data_exception; end
      end
    end
    n_vec++; if (fe !== 33) begin n_err++; $display("FAIL postrst_rdy_edge got %0d want 33", fe); end
    n_vec++; if (ns !== 1) begin n_err++; $display("FAIL postrst_strobes got %0d want 1", ns); end
    n_vec++; if (r !== 32'd3) begin n_err++; $display("FAIL postrst_result got %h want 00000003", r); end
    n_vec++; if (x !== 1'b0) begin n_err++; $display("FAIL postrst_exc got %b want 0", x); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_restart();
    test_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
